// File: rtl/dcsk_modulator_if.sv
// DCSK modulator chip/bit bus: strobe, chip counter, chaos sample and bit handshake in;
// modulated chip stream and status out.
interface dcsk_modulator_if;
  logic              i_en;
  logic [1:0]        i_sf;
  logic [4:0]        i_chip_index;
  logic              i_chip_index_msb;
  logic signed [7:0] i_chaos_chip;
  logic              i_bit;
  logic              i_bit_valid;
  logic              o_bit_ready;
  logic signed [7:0] o_chip;
  logic              o_chip_valid;
  logic              o_ref_phase;
  logic              o_frame_done;
  logic              o_underrun;
  logic              o_sf_err;

  modport master (
    output i_en, i_sf, i_chip_index, i_chip_index_msb, i_chaos_chip, i_bit, i_bit_valid,
    input  o_bit_ready, o_chip, o_chip_valid, o_ref_phase, o_frame_done, o_underrun, o_sf_err
  );

  modport slave (
    input  i_en, i_sf, i_chip_index, i_chip_index_msb, i_chaos_chip, i_bit, i_bit_valid,
    output o_bit_ready, o_chip, o_chip_valid, o_ref_phase, o_frame_done, o_underrun, o_sf_err
  );
endinterface

// File: rtl/dcsk_modulator.sv
// DCSK modulator: the reference half forwards chaos samples and stores them; the data half
// replays them, negated for bit 0. One-deep bit holding register, one cycle output latency.
module dcsk_modulator (
  input logic             i_clk,
  input logic             i_rst,
  dcsk_modulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REF, DATA} state_t;

  state_t            state;
  logic [1:0]        sf_q;
  logic              frame_bit;
  logic              silent;
  logic              full;
  logic              held_bit;
  logic signed [7:0] ref_buf [16];

  logic [5:0]        half_len;
  logic [5:0]        frame_len;
  logic [3:0]        offset;
  logic              at_chip0;
  logic              consume;
  logic              load;
  logic              in_range;
  logic              last_chip;
  logic              ref_wr;
  logic signed [7:0] ref_val;
  logic signed [7:0] data_val;

  assign at_chip0 = (bus.i_chip_index == 5'd0);
  assign consume  = bus.i_en & at_chip0;
  assign bus.o_bit_ready = ~full | consume;
  assign load     = bus.i_bit_valid & bus.o_bit_ready;

  // Mid-frame geometry always follows the SF latched at chip 0.
  assign half_len  = 6'd2 << sf_q;
  assign frame_len = half_len << 1;
  assign offset    = bus.i_chip_index[3:0] & (half_len[3:0] - 4'd1);
  assign in_range  = ({1'b0, bus.i_chip_index} < frame_len);
  assign last_chip = ({1'b0, bus.i_chip_index} == frame_len - 6'd1);

  assign ref_val  = ref_buf[offset];
  assign data_val = frame_bit ? ref_val
                  : ((ref_val == -8'sd128) ? 8'sd127 : -ref_val);

  assign ref_wr = at_chip0 | ((state == REF) & in_range & ~bus.i_chip_index_msb);

  always_ff @(posedge i_clk) begin
    if (!i_rst && bus.i_en && ref_wr)
      ref_buf[offset] <= bus.i_chaos_chip;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      sf_q             <= 2'd0;
      frame_bit        <= 1'b0;
      silent           <= 1'b0;
      full             <= 1'b0;
      held_bit         <= 1'b0;
      bus.o_chip       <= 8'sd0;
      bus.o_chip_valid <= 1'b0;
      bus.o_ref_phase  <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_underrun   <= 1'b0;
      bus.o_sf_err     <= 1'b0;
    end else begin
      // Load wins over consume: a bit offered at chip 0 refills the register just emptied.
      if (load) begin
        full     <= 1'b1;
        held_bit <= bus.i_bit;
      end else if (consume) begin
        full <= 1'b0;
      end

      bus.o_chip_valid <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_underrun   <= 1'b0;

      if (bus.i_en) begin
        if (at_chip0) begin
          state            <= REF;
          sf_q             <= bus.i_sf;
          frame_bit        <= held_bit;
          silent           <= ~full;
          bus.o_chip       <= full ? bus.i_chaos_chip : 8'sd0;
          bus.o_chip_valid <= 1'b1;
          bus.o_ref_phase  <= 1'b1;
          bus.o_underrun   <= ~full;
        end else if (state != IDLE && in_range) begin
          if (bus.i_sf != sf_q)
            bus.o_sf_err <= 1'b1;
          if (!bus.i_chip_index_msb && state == REF) begin
            bus.o_chip       <= silent ? 8'sd0 : bus.i_chaos_chip;
            bus.o_chip_valid <= 1'b1;
            bus.o_ref_phase  <= 1'b1;
          end else if (bus.i_chip_index_msb) begin
            state            <= last_chip ? IDLE : DATA;
            bus.o_chip       <= silent ? 8'sd0 : data_val;
            bus.o_chip_valid <= 1'b1;
            bus.o_ref_phase  <= 1'b0;
            bus.o_frame_done <= last_chip;
          end
        end
      end
    end
  end
endmodule

// File: doc/dcsk_modulator.md
DCSK_MODULATOR -- requirements
Module: dcsk_modulator

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_en  input  1  chip strobe; same signal that advances the upstream chip/bit counter.
REQ-005 i_sf  input  2  spreading factor: SF2=2'b00, SF4=2'b01, SF8=2'b10, SF16=2'b11, per spreading_factors_pkg.
REQ-006 i_chip_index  input  5  chip index within the current bit frame, from the chip/bit counter.
REQ-007 i_chip_index_msb  input  1  0 = reference half, 1 = data half.
REQ-008 i_chaos_chip  input  8  signed chaotic sample, consumed on enabled reference-half cycles.
REQ-009 i_bit  input  1  data bit to send (1 = +ref, 0 = -ref).
REQ-010 i_bit_valid  input  1  i_bit is valid.
REQ-011 o_bit_ready  output  1  holding register can accept a bit this cycle.
REQ-012 o_chip  output  8  signed modulated chip, registered.
REQ-013 o_chip_valid  output  1  o_chip is valid.
REQ-014 o_ref_phase  output  1  o_chip belongs to the reference half.
REQ-015 o_frame_done  output  1  one-cycle pulse with the last chip of a frame.
REQ-016 o_underrun  output  1  one-cycle pulse: no bit available at frame start.
REQ-017 o_sf_err  output  1  sticky: i_sf changed mid-frame.

Function
REQ-018 Half length H = 2^(sf+1): 2/4/8/16 chips; frame = 2H chips; reference-half offset = i_chip_index[log2(H)-1:0].
REQ-019 FSM states are IDLE, REF and DATA.
- IDLE->REF on i_en with i_chip_index==0.
- REF->DATA on the first enabled cycle with i_chip_index_msb=1.
- DATA->REF at chip 0 when i_en is high; otherwise DATA->IDLE after the last chip.
REQ-020 i_en low: no state, buffer or output register changes except the bit handshake; o_chip_valid=0 next cycle.
REQ-021 Bit holding register, 1 deep: o_bit_ready = ~full | consume; a load occurs when i_bit_valid & o_bit_ready.
REQ-022 Consume occurs on an enabled cycle with i_chip_index==0; the bit latched for the frame is the held bit; load and consume in the same cycle are both honoured.
REQ-023 Empty at consume: frame is marked silent, o_underrun pulses with chip 0, and every chip of that frame outputs 8'sd0 with o_chip_valid=1.
REQ-024 Enabled REF cycle: ref_buf[offset] <= i_chaos_chip; o_chip <= i_chaos_chip.
REQ-025 Enabled DATA cycle: o_chip <= ref_buf[offset] when the bit is 1, else -ref_buf[offset]; the negation of -128 saturates to +127.
REQ-026 Latency is 1 cycle from the enabled input cycle to o_chip/o_chip_valid/o_ref_phase.
REQ-027 o_frame_done is asserted with the output of chip index 2H-1.
REQ-028 i_sf is latched at chip 0; any enabled cycle within the frame with i_sf differing from the latched value sets o_sf_err; the frame completes using the latched SF.
REQ-029 Chip indices with i_chip_index >= 2H are ignored, with no output.

Reset
REQ-030 i_rst at a clock edge: FSM=IDLE, holding register empty, all outputs 0, o_sf_err cleared; ref_buf contents are don't-care.
REQ-031 Reset asserted mid-frame aborts the frame; the first frame after reset starts at the next enabled chip 0.

Verification
REQ-032 SF2, bit=1, chaos 10,-20 -> o_chip 10,-20,10,-20; o_ref_phase 1,1,0,0; o_frame_done on the 4th chip.
REQ-033 SF4, bit=0, chaos 5,-128,0,127 -> data half -5,127,0,-127.
REQ-034 No i_bit_valid before chip 0 -> o_underrun pulses; 8 zero chips with valid=1; o_bit_ready stays 1.
REQ-035 Bit offered at chip 0 while full -> load and consume in the same cycle; next frame uses the new bit; no underrun.
REQ-036 SF16 frame with i_sf switched to SF8 at chip 7 -> o_sf_err=1; 32 chips still output.
REQ-037 i_rst at SF8 chip 9 -> all outputs 0 next cycle; clean frame from the next chip 0.
